// File: rtl/mem_main_arb_if.sv
// Requester, completion and memory-port signals of the main-memory arbiter.
// The slave view is the arbiter itself; the master view is its environment.
interface mem_main_arb_if #(
   parameter int NUM_RT = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128
);
   logic [NUM_RT-1:0]             we_RT;
   logic [NUM_RT-1:0]             re_RT;
   logic [NUM_RT-1:0][ADDR_W-1:0] addr_RT;
   logic [NUM_RT-1:0][DATA_W-1:0] data_RT_in;
   logic                          re_MC;
   logic [ADDR_W-1:0]             addr_MC;
   logic [NUM_RT-1:0]             rdy_RT;
   logic [NUM_RT-1:0][DATA_W-1:0] data_RT_out;
   logic                          rdy_MC;
   logic [DATA_W-1:0]             data_MC_out;
   logic                          mem_we;
   logic                          mem_re;
   logic [ADDR_W-1:0]             mem_addr;
   logic [DATA_W-1:0]             mem_wdata;
   logic [DATA_W-1:0]             mem_rdata;
   logic                          mem_rvalid;

   modport slave (
      input  we_RT, re_RT, addr_RT, data_RT_in, re_MC, addr_MC, mem_rdata, mem_rvalid,
      output rdy_RT, data_RT_out, rdy_MC, data_MC_out, mem_we, mem_re, mem_addr, mem_wdata
   );

   modport master (
      output we_RT, re_RT, addr_RT, data_RT_in, re_MC, addr_MC, mem_rdata, mem_rvalid,
      input  rdy_RT, data_RT_out, rdy_MC, data_MC_out, mem_we, mem_re, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_main_arb.sv
// Shares single-ported main memory between NUM_RT ray-tracer cores and the MC, one access at a time.
// Define MEM_ARB_MC_PRIORITY_EN to give MC fixed top priority over the round-robin RT slots.
module mem_main_arb #(
   parameter int NUM_RT = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128
) (
   input logic            clk,
   input logic            rst_n,
   mem_main_arb_if.slave  bus
);
   localparam int SLOTS = NUM_RT + 1;
   localparam int SW    = $clog2(SLOTS);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [SW-1:0]     rr_ptr;
   logic [SW-1:0]     win;
   logic              wr_op;
   logic [SLOTS-1:0]  req;
   logic [SW-1:0]     pick;
   logic              pick_vld;
   logic              pick_wr;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;

   assign req = {bus.re_MC, bus.we_RT | bus.re_RT};

   always_comb begin
      int idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
`ifdef MEM_ARB_MC_PRIORITY_EN
      if (bus.re_MC) begin
         pick     = SW'(NUM_RT);
         pick_vld = 1'b1;
      end else begin
         for (int k = 0; k < NUM_RT; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_RT;
            if (!pick_vld && req[idx]) begin
               pick     = SW'(idx);
               pick_vld = 1'b1;
            end
         end
      end
`else
      for (int k = 0; k < SLOTS; k++) begin
         idx = (int'(rr_ptr) + k) % SLOTS;
         if (!pick_vld && req[idx]) begin
            pick     = SW'(idx);
            pick_vld = 1'b1;
         end
      end
`endif
   end

   // MC slot falls through the loop: read-only, no write data
   always_comb begin
      pick_wr    = 1'b0;
      pick_addr  = bus.addr_MC;
      pick_wdata = '0;
      for (int i = 0; i < NUM_RT; i++) begin
         if (pick == SW'(i)) begin
            pick_wr    = bus.we_RT[i];
            pick_addr  = bus.addr_RT[i];
            pick_wdata = bus.data_RT_in[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      bus.mem_we = 1'b0;
      bus.mem_re = 1'b0;
      bus.rdy_RT = '0;
      bus.rdy_MC = 1'b0;
      case (state)
         IDLE:  if (pick_vld) state_nxt = ISSUE;
         ISSUE: begin
            bus.mem_we = wr_op;
            bus.mem_re = !wr_op;
            state_nxt  = wr_op ? DONE : WAIT;
         end
         WAIT:  if (bus.mem_rvalid) state_nxt = DONE;
         DONE: begin
            bus.rdy_MC = (win == SW'(NUM_RT));
            for (int i = 0; i < NUM_RT; i++) bus.rdy_RT[i] = (win == SW'(i));
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr          <= '0;
         win             <= '0;
         wr_op           <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.data_RT_out <= '0;
         bus.data_MC_out <= '0;
      end else begin
         if (state == IDLE && pick_vld) begin
            win           <= pick;
            wr_op         <= pick_wr;
            bus.mem_addr  <= pick_addr;
            bus.mem_wdata <= pick_wdata;
         end
         if (state == ISSUE) begin
`ifdef MEM_ARB_MC_PRIORITY_EN
            // MC grants leave the RT rotation untouched
            if (win != SW'(NUM_RT))
               rr_ptr <= (win == SW'(NUM_RT - 1)) ? '0 : win + SW'(1);
`else
            rr_ptr <= (win == SW'(NUM_RT)) ? '0 : win + SW'(1);
`endif
         end
         if (state == WAIT && bus.mem_rvalid) begin
            if (win == SW'(NUM_RT)) bus.data_MC_out <= bus.mem_rdata;
            for (int i = 0; i < NUM_RT; i++)
               if (win == SW'(i)) bus.data_RT_out[i] <= bus.mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_mem_main_arb.sv
// Directed bench for mem_main_arb: write, read, write precedence, reset mid-read,
// and either round-robin fairness or MC priority depending on MEM_ARB_MC_PRIORITY_EN.
module tb_mem_main_arb;
   localparam int NUM_RT = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 128;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   mem_main_arb_if #(.NUM_RT(NUM_RT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_main_arb #(.NUM_RT(NUM_RT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] slot_addr(input int slot);
      return (slot == NUM_RT) ? 32'h200 : 32'h100 + 32'(slot * 16);
   endfunction

   function automatic logic [DATA_W-1:0] slot_data(input int slot);
      return (slot == NUM_RT) ? bus.data_MC_out : bus.data_RT_out[slot];
   endfunction

   // Entered with the FSM in IDLE and the requester already asserting its read
   task automatic do_read(input int slot, input logic [DATA_W-1:0] rd);
      logic [NUM_RT:0] exp_rdy;
      exp_rdy       = '0;
      exp_rdy[slot] = 1'b1;
      step();
      chk("rd_mem_re", bus.mem_re, 1);
      chk("rd_mem_addr", bus.mem_addr, slot_addr(slot));
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rd;
      step();
      bus.mem_rvalid = 1'b0;
      chk("rd_rdy_onehot", {bus.rdy_MC, bus.rdy_RT}, exp_rdy);
      chk("rd_data_out", slot_data(slot), rd);
      step();
      chk("rd_rdy_clear", {bus.rdy_MC, bus.rdy_RT}, 0);
   endtask

   initial begin
      logic [1:0] st;
      rst_n          = 1'b0;
      bus.we_RT      = '0;
      bus.re_RT      = '0;
      bus.addr_RT    = '0;
      bus.data_RT_in = '0;
      bus.re_MC      = 1'b0;
      bus.addr_MC    = '0;
      bus.mem_rdata  = '0;
      bus.mem_rvalid = 1'b0;
      repeat (3) step();

      chk("rst_rdy", {bus.rdy_MC, bus.rdy_RT}, 0);
      chk("rst_mem_strobes", {bus.mem_we, bus.mem_re}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_data_rt", bus.data_RT_out, 0);
      chk("rst_data_mc", bus.data_MC_out, 0);
      chk("rst_rr_ptr", dut.rr_ptr, 0);
      rst_n = 1'b1;
      step();

      // RT0 write
      bus.we_RT[0]      = 1'b1;
      bus.addr_RT[0]    = 32'h10;
      bus.data_RT_in[0] = {4{32'hA5A5A5A5}};
      step();
      chk("wr_mem_we", bus.mem_we, 1);
      chk("wr_mem_re", bus.mem_re, 0);
      chk("wr_mem_addr", bus.mem_addr, 32'h10);
      chk("wr_mem_wdata", bus.mem_wdata, {4{32'hA5A5A5A5}});
      chk("wr_rdy_early", {bus.rdy_MC, bus.rdy_RT}, 0);
      step();
      chk("wr_rdy", {bus.rdy_MC, bus.rdy_RT}, 5'b00001);
      chk("wr_mem_we_off", bus.mem_we, 0);
      bus.we_RT[0] = 1'b0;
      step();
      chk("wr_rdy_clear", {bus.rdy_MC, bus.rdy_RT}, 0);
      chk("wr_data_out0", bus.data_RT_out[0], 0);
      chk("wr_rr_ptr", dut.rr_ptr, 1);

      // RT1 read, rvalid three cycles after mem_re
      bus.re_RT[1]   = 1'b1;
      bus.addr_RT[1] = 32'h40;
      step();
      chk("rd1_mem_re", bus.mem_re, 1);
      chk("rd1_mem_we", bus.mem_we, 0);
      chk("rd1_mem_addr", bus.mem_addr, 32'h40);
      step();
      chk("rd1_mem_re_off", bus.mem_re, 0);
      step();
      chk("rd1_wait_rdy", {bus.rdy_MC, bus.rdy_RT}, 0);
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 128'hDEAD_BEEF;
      step();
      bus.mem_rvalid = 1'b0;
      chk("rd1_rdy", {bus.rdy_MC, bus.rdy_RT}, 5'b00010);
      chk("rd1_data1", bus.data_RT_out[1], 128'hDEAD_BEEF);
      chk("rd1_data0", bus.data_RT_out[0], 0);
      chk("rd1_data_mc", bus.data_MC_out, 0);
      bus.re_RT[1] = 1'b0;
      step();
      chk("rd1_rdy_clear", {bus.rdy_MC, bus.rdy_RT}, 0);

      // RT3 with we and re both high behaves as a write
      bus.we_RT[3]   = 1'b1;
      bus.re_RT[3]   = 1'b1;
      bus.addr_RT[3] = 32'h80;
      step();
      chk("wp_mem_we", bus.mem_we, 1);
      chk("wp_mem_re", bus.mem_re, 0);
      chk("wp_mem_addr", bus.mem_addr, 32'h80);
      step();
      chk("wp_rdy", {bus.rdy_MC, bus.rdy_RT}, 5'b01000);
      chk("wp_mem_re_done", bus.mem_re, 0);
      bus.we_RT[3] = 1'b0;
      bus.re_RT[3] = 1'b0;
      step();
      chk("wp_data3", bus.data_RT_out[3], 0);

      // Reset while RT2 read waits for data, then a stray rvalid
      bus.re_RT[2]   = 1'b1;
      bus.addr_RT[2] = 32'h60;
      step();
      chk("rs_mem_re", bus.mem_re, 1);
      step();
      rst_n        = 1'b0;
      bus.re_RT[2] = 1'b0;
      #1;
      chk("rs_rdy", {bus.rdy_MC, bus.rdy_RT}, 0);
      chk("rs_mem", {bus.mem_we, bus.mem_re, bus.mem_addr}, 0);
      chk("rs_data_rt", bus.data_RT_out, 0);
      step();
      rst_n = 1'b1;
      step();
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 128'h1234_5678;
      step();
      bus.mem_rvalid = 1'b0;
      st = dut.state;
      chk("rs_state_idle", st, 0);
      chk("rs_rr_ptr", dut.rr_ptr, 0);
      chk("rs_stray_rdy", {bus.rdy_MC, bus.rdy_RT}, 0);
      chk("rs_stray_data", bus.data_RT_out, 0);
      chk("rs_stray_mc", bus.data_MC_out, 0);
      step();
      chk("rs_stray_rdy2", {bus.rdy_MC, bus.rdy_RT}, 0);

      for (int i = 0; i < NUM_RT; i++) bus.addr_RT[i] = slot_addr(i);
      bus.addr_MC = slot_addr(NUM_RT);
`ifdef MEM_ARB_MC_PRIORITY_EN
      bus.re_RT[2] = 1'b1;
      bus.re_MC    = 1'b1;
      for (int g = 0; g < 3; g++) do_read(NUM_RT, 128'hC0DE_0000 + 128'(g));
      chk("pr_rr_ptr", dut.rr_ptr, 0);
      bus.re_MC = 1'b0;
      do_read(2, 128'hBEEF_0002);
      bus.re_RT[2] = 1'b0;
      chk("pr_rr_ptr_rt", dut.rr_ptr, 3);
`else
      bus.re_RT = '1;
      bus.re_MC = 1'b1;
      for (int g = 0; g < 10; g++) do_read(g % (NUM_RT + 1), 128'hC0DE_0000 + 128'(g));
      bus.re_RT = '0;
      bus.re_MC = 1'b0;
      chk("rr_ptr_wrap", dut.rr_ptr, 0);
`endif
      step();
      chk("end_idle_rdy", {bus.rdy_MC, bus.rdy_RT}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_main_arb.md
Name: mem_main_arb

Overview:
- Arbiter/sequencer that shares the single-ported main memory between NUM_RT ray-tracer cores (read/write) and the memory controller MC (read-only).
- Sits between requesters and the memory array. Accepts level-held requests, grants one at a time, drives one memory access, returns a one-cycle rdy pulse plus registered read data per requester.
- One transaction in flight at a time.

Parameters:
- NUM_RT, 4, number of ray-tracer requesters; MC is arbitration slot index NUM_RT
- ADDR_W, 32, address width
- DATA_W, 128, data width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- we_RT  in  [NUM_RT] x 1  RT write request, level, held until rdy_RT
- re_RT  in  [NUM_RT] x 1  RT read request, level, held until rdy_RT
- addr_RT  in  [NUM_RT] x ADDR_W  RT address
- data_RT_in  in  [NUM_RT] x DATA_W  RT write data
- re_MC  in  1  MC read request, held until rdy_MC
- addr_MC  in  ADDR_W  MC address
- rdy_RT  out  [NUM_RT] x 1  one-cycle completion pulse per RT
- data_RT_out  out  [NUM_RT] x DATA_W  registered read data per RT
- rdy_MC  out  1  one-cycle completion pulse for MC
- data_MC_out  out  DATA_W  registered read data for MC
- mem_we  out  1  memory write strobe, one cycle
- mem_re  out  1  memory read strobe, one cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid
- mem_rvalid  in  1  read-data-valid pulse from memory

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including every data_*_out register.
- Request: slot i (i<NUM_RT) requests when we_RT[i]|re_RT[i]; slot NUM_RT requests when re_MC.
  - we and re both high: treated as write only.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request, choose winner by round-robin: first requesting slot searching upward from rr_ptr, wrapping modulo NUM_RT+1.
  - Latch winner index, op, addr and wdata. Go to ISSUE.
  - Else stay in IDLE.
- ISSUE:
  - Drive mem_we or mem_re =1 for exactly this cycle, with latched mem_addr/mem_wdata.
  - Set rr_ptr = (winner+1) mod (NUM_RT+1).
  - Write goes to DONE; read goes to WAIT.
- WAIT:
  - On mem_rvalid, capture mem_rdata into the winner's data_*_out register. Go to DONE.
  - No timeout; waits indefinitely.
- DONE:
  - Pulse the winner's rdy for one cycle. Go to IDLE.
  - The requester may deassert or change its request from the next cycle.
  - A held request in IDLE is re-arbitrated as a new transaction.
- Latency:
  - Write: request seen in IDLE at cycle 0, mem_we at cycle 1, rdy at cycle 2.
  - Read: rdy the cycle after mem_rvalid is sampled.
  - Minimum gap between grants is 3 cycles.
- data_*_out: updated only on that requester's read completion; otherwise holds its value. Writes do not modify it.
- mem_addr/mem_wdata: hold last issued values outside ISSUE. mem_we/mem_re are 0 outside ISSUE.
- mem_rvalid outside WAIT: ignored.
- Request withdrawn after latching: transaction still completes and rdy still pulses.
- Reset mid-transaction:
  - Immediate return to reset state; in-flight access abandoned, no rdy.
  - A later stray mem_rvalid is ignored.
- At most one rdy bit (over all rdy_RT and rdy_MC) high in any cycle.

Optional Feature:
- Macro MEM_ARB_MC_PRIORITY_EN.
- Defined: MC has fixed highest priority. In IDLE, re_MC wins over all RT requests. RT slots round-robin among themselves modulo NUM_RT; rr_ptr is unchanged by MC grants.
- Undefined: MC is ordinary round-robin slot NUM_RT, as described above.

Test Plan:
- Write: RT0 we, addr 0x10, data 0xA5A5...: mem_we=1 with mem_addr=0x10 at cycle 1; rdy_RT[0]=1 at cycle 2 only; data_RT_out[0] stays 0.
- Read: RT1 re, addr 0x40; bench asserts mem_rvalid with 0xDEAD_BEEF 3 cycles after mem_re. Expect rdy_RT[1] the next cycle, data_RT_out[1]=0xDEAD_BEEF, other data outputs unchanged.
- Fairness (macro undefined): all RT0-3 and MC hold reads, 1-cycle rvalid. Grant order 0,1,2,3,MC,0,1,...; never two rdy bits in the same cycle.
- Priority (MEM_ARB_MC_PRIORITY_EN): MC and RT2 hold reads. MC is granted every transaction while re_MC=1; RT2 is granted after re_MC drops.
- Reset: rst_n low in WAIT, then released; stray mem_rvalid 2 cycles later. All outputs 0, no rdy, FSM in IDLE, rr_ptr=0.
- Write precedence: RT3 we=re=1, addr 0x80. Only mem_we pulses, no mem_re; rdy_RT[3] at cycle 2.
